// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: read-owner tag, age width, grant vector layout, core constants.
// No logic, so no latency.
// No flow control; constants and types only.
package mips32_pkg;

    // Width of the instruction-port anti-starvation age counter.
    localparam int AGE_W = 4;

    // Default data width of the core and its memory.
    localparam int DW_DEF = 32;

    // Primary opcode the core treats as halt.
    localparam logic [5:0] OP_HLT = 6'h3f;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_H = 0;
    localparam int GNT_D = 1;
    localparam int GNT_I = 2;

    // Which requester owns the read data returning next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Request/grant/read-return bundle between H/D/I requesters, the arbiter and the RAM.
// Wires only, so no latency.
// Requesters hold req and fields until their gnt; the RAM never stalls.
interface mips32_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          host_lock;

    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] h_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  host_lock,
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/RAM side.
    modport master (
        output host_lock,
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mips32_prio_sel.sv
// Fixed-priority H > D > I select; promote lifts I above D, lock leaves only H eligible.
// Purely combinational, grant in the same cycle as the request.
// Losers simply see no grant and must keep requesting.
module mips32_prio_sel
    import mips32_pkg::*;
(
    input  logic       req_h,
    input  logic       req_d,
    input  logic       req_i,
    input  logic       promote,
    input  logic       lock,
    output logic [2:0] gnt
);

    // One-hot winner: host always first, then I or D depending on promotion.
    always_comb begin
        gnt = '0;
        if (req_h) begin
            gnt[GNT_H] = 1'b1;
        end else if (!lock) begin
            if (req_i && promote) begin
                gnt[GNT_I] = 1'b1;
            end else if (req_d) begin
                gnt[GNT_D] = 1'b1;
            end else if (req_i) begin
                gnt[GNT_I] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port RAM arbiter for host (H), data (D) and fetch (I); optional MEM_ARB_PERF_EN counters.
// Grant same cycle as req; read data returns one cycle after grant, fully pipelined.
// Losing requester gets no gnt (I also sees i_stall) and holds its request; RAM side never stalls.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = DW_DEF,
    parameter int AGE_MAX = 4
) (
    input  logic clk1,
    input  logic rst,
    mips32_mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] gnt_cnt_h,
    output logic [31:0] gnt_cnt_d,
    output logic [31:0] gnt_cnt_i,
    output logic [31:0] conflict_cnt
`endif
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] AGE_SAT = '1;

    logic [AGE_W-1:0] age_cnt;
    logic             promote;
    logic [2:0]       sel_gnt;
    logic [2:0]       gnt;
    owner_e           owner;
    owner_e           owner_nxt;
    logic             mux_we;
    logic [AW-1:0]    mux_addr;
    logic [DW-1:0]    mux_wdata;

    assign promote = (age_cnt >= AGE_LIM);

    mips32_prio_sel u_prio_sel (
        .req_h   (bus.h_req),
        .req_d   (bus.d_req),
        .req_i   (bus.i_req),
        .promote (promote),
        .lock    (bus.host_lock),
        .gnt     (sel_gnt)
    );

    // Nothing is granted while reset is held, so the RAM stays idle.
    assign gnt = rst ? 3'b000 : sel_gnt;

    assign bus.h_gnt   = gnt[GNT_H];
    assign bus.d_gnt   = gnt[GNT_D];
    assign bus.i_gnt   = gnt[GNT_I];
    assign bus.i_stall = bus.i_req & ~gnt[GNT_I];

    // Route the winner's access fields onto the RAM port.
    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (gnt[GNT_H]) begin
            mux_we    = bus.h_we;
            mux_addr  = bus.h_addr;
            mux_wdata = bus.h_wdata;
        end else if (gnt[GNT_D]) begin
            mux_we    = bus.d_we;
            mux_addr  = bus.d_addr;
            mux_wdata = bus.d_wdata;
        end else if (gnt[GNT_I]) begin
            mux_addr  = bus.i_addr;
        end
    end

    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = mux_we;
    assign bus.mem_addr  = mux_addr;
    assign bus.mem_wdata = mux_wdata;

    // Tag the read granted this cycle; writes and idle cycles leave no return pending.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (gnt[GNT_H] && !bus.h_we) begin
            owner_nxt = OWN_H;
        end else if (gnt[GNT_D] && !bus.d_we) begin
            owner_nxt = OWN_D;
        end else if (gnt[GNT_I]) begin
            owner_nxt = OWN_I;
        end
    end

    // Owner register; reset drops any read still in flight.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    assign bus.h_rvalid = (owner == OWN_H);
    assign bus.d_rvalid = (owner == OWN_D);
    assign bus.i_rvalid = (owner == OWN_I);
    assign bus.h_rdata  = (owner == OWN_H) ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (owner == OWN_D) ? bus.mem_rdata : '0;
    assign bus.i_rdata  = (owner == OWN_I) ? bus.mem_rdata : '0;

    // Count consecutive cycles a fetch loses to D; frozen during host lock.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (!bus.host_lock) begin
            if (bus.i_req && !gnt[GNT_I]) begin
                if (age_cnt != AGE_SAT) begin
                    age_cnt <= age_cnt + 1'b1;
                end
            end else begin
                age_cnt <= '0;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [1:0] n_req;

    assign n_req = {1'b0, bus.h_req} + {1'b0, bus.d_req} + {1'b0, bus.i_req};

    // Free-running grant and contention counters, wrapping at 2^32.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            gnt_cnt_h    <= '0;
            gnt_cnt_d    <= '0;
            gnt_cnt_i    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt[GNT_H]) gnt_cnt_h <= gnt_cnt_h + 32'd1;
            if (gnt[GNT_D]) gnt_cnt_d <= gnt_cnt_d + 32'd1;
            if (gnt[GNT_I]) gnt_cnt_i <= gnt_cnt_i + 32'd1;
            if (n_req >= 2'd2) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios plus random traffic against a shadow-memory model.
// Grants checked in-cycle; read returns checked by a monitor one cycle after grant.
// Covers MEM_ARB_PERF_EN counters when that macro is defined.
module tb_mips32_mem_arbiter;
    import mips32_pkg::*;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int AGE_MAX = 4;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] gch, gcd, gci, ccnt;
`endif

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .AGE_MAX(AGE_MAX)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .gnt_cnt_h    (gch),
        .gnt_cnt_d    (gcd),
        .gnt_cnt_i    (gci),
        .conflict_cnt (ccnt)
`endif
    );

    // Synchronous RAM, one-cycle read latency.
    logic [DW-1:0] ram [1 << AW];
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        int            who;   // 1=H 2=D 3=I
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] mmem [1 << AW];
    int            m_age;
    int            last_g;
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbitration straight from the priority rules.
    function automatic int model_grant();
        if (rst)                               return 0;
        if (bus.h_req)                         return 1;
        if (bus.host_lock)                     return 0;
        if (bus.i_req && m_age >= AGE_MAX)     return 3;
        if (bus.d_req)                         return 2;
        if (bus.i_req)                         return 3;
        return 0;
    endfunction

    function automatic logic [2:0] oh(input int g);
        case (g)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Called at posedge+1 with inputs applied; checks grant, updates model, returns at next posedge+1.
    task automatic step();
        int            g;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        #2;
        g      = model_grant();
        last_g = g;
        we = 1'b0; a = '0; wd = '0;
        check("gnt", {bus.h_gnt, bus.d_gnt, bus.i_gnt}, oh(g));
        check("i_stall", bus.i_stall, bus.i_req && (g != 3));
        check("mem_en", bus.mem_en, g != 0);
        if (rst) check("rst_mem_we", bus.mem_we, 1'b0);
        if (g != 0) begin
            case (g)
                1: begin we = bus.h_we; a = bus.h_addr; wd = bus.h_wdata; end
                2: begin we = bus.d_we; a = bus.d_addr; wd = bus.d_wdata; end
                default: begin we = 1'b0; a = bus.i_addr; end
            endcase
            check("mem_we", bus.mem_we, we);
            check("mem_addr", bus.mem_addr, a);
            if (we) begin
                check("mem_wdata", bus.mem_wdata, wd);
                mmem[a] = wd;
            end else begin
                exp_q.push_back('{g, mmem[a]});
            end
        end
        if (rst) m_age = 0;
        else if (!bus.host_lock) begin
            if (bus.i_req && g != 3) m_age = (m_age < 15) ? m_age + 1 : 15;
            else                     m_age = 0;
        end
        @(posedge clk1);
        #1;
    endtask

    // Read-return monitor: each granted read must come back on exactly the next cycle.
    always @(posedge clk1) begin
        rd_t           e;
        logic [2:0]    erv;
        logic [DW-1:0] eh, ed, ei;
        #2;
        erv = '0; eh = '0; ed = '0; ei = '0;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            erv = oh(e.who);
            case (e.who)
                1:       eh = e.data;
                2:       ed = e.data;
                default: ei = e.data;
            endcase
        end
        check("rvalid", {bus.h_rvalid, bus.d_rvalid, bus.i_rvalid}, erv);
        check("rdata", {bus.h_rdata, bus.d_rdata, bus.i_rdata}, {eh, ed, ei});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_i;
        bit ph, pd, pi;

        for (int k = 0; k < (1 << AW); k++) begin
            ram[k]  = 32'hA000_0000 + k;
            mmem[k] = 32'hA000_0000 + k;
        end
        m_age = 0;
        bus.host_lock = 0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.mem_rdata = '0;

        // Reset: requests present but nothing may be granted.
        @(posedge clk1); #1;
        bus.h_req = 1; bus.d_req = 1; bus.i_req = 1;
        step();
        check("rst_age", dut.age_cnt, 0);
        bus.h_req = 0; bus.d_req = 0; bus.i_req = 0;
        rst = 0;
        step();

        // Host lock: load Mem[100..119] = 20..1 while D/I wait, then read back 105.
        bus.host_lock = 1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 100;
        bus.i_req = 1; bus.i_addr = 0;
        for (int k = 0; k < 20; k++) begin
            bus.h_req = 1; bus.h_we = 1; bus.h_addr = AW'(100 + k); bus.h_wdata = DW'(20 - k);
            step();
        end
        bus.h_we = 0; bus.h_addr = 105;
        step();
        bus.h_req = 0;
        check("h_rvalid_105", bus.h_rvalid, 1'b1);
        check("h_rdata_105", bus.h_rdata, 32'd15);
        check("age_hold_lock", dut.age_cnt, 0);

        // Unlock: D wins first, then I; returns follow one cycle later.
        bus.host_lock = 0;
        step();
        check("first_unlock_d", last_g, 2);
        bus.d_req = 0;
        check("d_rvalid_100", bus.d_rvalid, 1'b1);
        check("d_rdata_100", bus.d_rdata, 32'd20);
        step();
        check("then_i", last_g, 3);
        bus.i_req = 0;
        check("i_rdata_0", bus.i_rdata, 32'hA000_0000);
        step();

        // Starvation: D every cycle, I promoted on the AGE_MAX+1-th contended cycle.
        first_i = 0;
        bus.i_req = 1; bus.i_addr = 4;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 101;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (last_g == 3 && first_i == 0) begin
                first_i = n;
                check("age_clr", dut.age_cnt, 0);
            end
        end
        check("first_i_cycle", first_i, 5);
        bus.d_req = 0; bus.i_req = 0;
        step();

        // D write then I read of the same word sees the new data.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 110; bus.d_wdata = 32'h0000_0007;
        step();
        bus.d_req = 0; bus.d_we = 0;
        bus.i_req = 1; bus.i_addr = 110;
        step();
        bus.i_req = 0;
        check("i_rdata_raw", bus.i_rdata, 32'd7);
        check("no_d_rvalid_wr", bus.d_rvalid, 1'b0);
        step();

        // Reset the cycle after a D read grant: return discarded, clean restart.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 103;
        step();
        rst = 1;
        exp_q.delete();
        bus.h_req = 1; bus.i_req = 1;
        step();
        step();
        rst = 0;
        bus.h_req = 0; bus.i_req = 0;
        step();
        check("post_rst_d", last_g, 2);
        bus.d_req = 0;
        step();

        // Random traffic; each requester holds its request until granted.
        ph = 0; pd = 0; pi = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 31) == 0) bus.host_lock = ~bus.host_lock;
            if (!ph && $urandom_range(0, 3) == 0) begin
                ph = 1; bus.h_we = 1'($urandom_range(0, 1));
                bus.h_addr = AW'($urandom_range(0, 31)); bus.h_wdata = $urandom;
            end
            if (!pd && $urandom_range(0, 1) == 0) begin
                pd = 1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = AW'($urandom_range(0, 31)); bus.d_wdata = $urandom;
            end
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1; bus.i_addr = AW'($urandom_range(0, 31));
            end
            bus.h_req = ph; bus.d_req = pd; bus.i_req = pi;
            step();
            if (last_g == 1) ph = 0;
            if (last_g == 2) pd = 0;
            if (last_g == 3) pi = 0;
        end
        bus.host_lock = 0;
        bus.h_req = 0; bus.d_req = 0; bus.i_req = 0;
        step();
        step();

`ifdef MEM_ARB_PERF_EN
        // All three contend for 10 cycles: H takes every grant.
        rst = 1;
        exp_q.delete();
        step();
        rst = 0;
        check("perf_rst", {gch, gcd, gci}, 96'd0);
        bus.h_req = 1; bus.h_we = 0; bus.h_addr = 100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 101;
        bus.i_req = 1; bus.i_addr = 102;
        repeat (10) step();
        bus.h_req = 0; bus.d_req = 0; bus.i_req = 0;
        check("gnt_cnt_h", gch, 32'd10);
        check("conflict_cnt", ccnt, 32'd10);
        check("gnt_cnt_d", gcd, 32'd0);
        check("gnt_cnt_i", gci, 32'd0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Arbitrates the single-port unified memory between three requesters: host loader/debug port (H), MEM-stage data port (D) and IF-stage instruction port (I).
- Sits between the pipeline core and a synchronous RAM with 1-cycle read latency, clocked on clk1.
- Fixed priority with an anti-starvation promotion for I, plus a host lock used for bulk program/data loading before the pipeline is released.

Parameters:
- AW, 10, memory word-address width.
- DW, 32, data width.
- AGE_MAX, 4, consecutive denied cycles after which a pending I request is promoted above D; legal range 1..15.

Ports:
- clk1  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_lock  in  1  while high, only H may be granted.
- h_req / h_we  in  1 / 1  host request and write enable.
- h_addr  in  AW  host address.
- h_wdata  in  DW  host write data.
- h_gnt  out  1  host granted this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  DW  host read data.
- d_req / d_we / d_addr / d_wdata  in  1/1/AW/DW  data-port request, same meaning as host.
- d_gnt / d_rvalid / d_rdata  out  1/1/DW  data-port grant and read return.
- i_req  in  1  instruction fetch request (read only).
- i_addr  in  AW  fetch address.
- i_gnt / i_rvalid / i_rdata  out  1/1/DW  fetch grant and read return.
- i_stall  out  1  i_req & ~i_gnt; freezes PC/IF.
- mem_en / mem_we  out  1 / 1  RAM enable and write.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Grant is combinational, same cycle as req. At most one gnt is high per cycle. The granted requester's we/addr/wdata drive the mem_* outputs, and mem_en = any gnt. A requester holds req and its fields stable until gnt.
- Priority when host_lock=0: H > D > I. If age_cnt >= AGE_MAX and i_req, order becomes H > I > D.
- host_lock=1: only H is eligible. d_gnt=0, i_gnt=0 and i_stall follows i_req.
- Read return:
  - A registered owner tag {NONE,H,D,I} records a granted read.
  - The next cycle, exactly that requester's rvalid pulses for 1 cycle, and its rdata = mem_rdata.
  - Other rdata outputs are 0.
  - Writes set the tag to NONE; write completes at grant, no rvalid.
- Back-to-back reads are fully pipelined: a new grant may occur in the same cycle as a previous rvalid. Throughput is 1 access/cycle.
- age_cnt, 4-bit:
  - Reset 0.
  - Increments when i_req & ~i_gnt & ~host_lock, saturating at 15.
  - Clears on i_gnt or ~i_req.
  - Holds while host_lock=1.
- Simultaneous write and read to the same address in consecutive cycles: read returns the new data. This relies on RAM write-before-read ordering across cycles, not on forwarding.
- Reset, asynchronous: all gnt/rvalid/mem_en/mem_we=0, rdata=0, owner=NONE, age_cnt=0.
  - Reset mid-read discards the pending return; no rvalid after reset release.
- i_stall is purely combinational; it is 0 when i_req=0.

Optional Feature:
- MEM_ARB_PERF_EN defined: adds 32-bit counters gnt_cnt_h, gnt_cnt_d, gnt_cnt_i and conflict_cnt, exposed as output ports.
  - conflict_cnt increments each cycle with ≥2 reqs.
  - All counters are reset by rst and wrap at 2^32.
- Not defined: the counters and their ports are absent; arbitration is unchanged.

Decomposition:
- Shared package mips32_pkg holds:
  - the owner enum {OWN_NONE, OWN_H, OWN_D, OWN_I};
  - the AGE width constant;
  - the DW default and HLT opcode constants reused by the core.
- One natural sub-module, mips32_prio_sel: combinational 3-input priority select with promote and lock inputs, returning a one-hot grant. The top holds owner, age and the optional counters.

Test Plan:
- Reset then host_lock=1, host writes Mem[100..119]=20..1, then reads Mem[105] → h_gnt each cycle, h_rvalid 1 cycle later with h_rdata=15; d_gnt=i_gnt=0 throughout.
- host_lock=0, d_req read addr 100 and i_req addr 0 in same cycle → d_gnt=1, i_stall=1. Next cycle i_gnt=1 and d_rvalid with data 20. Following cycle i_rvalid.
- D requests every cycle for 6 cycles while i_req held, AGE_MAX=4 → i_gnt first asserted on the 5th contended cycle, D stalled that cycle, age_cnt returns to 0.
- D writes 0x0000_0007 to addr 110, next cycle I reads 110 → i_rdata=7, no d_rvalid for the write.
- Assert rst the cycle after a D read grant → d_rvalid never pulses, all outputs 0 while rst=1, normal grant on the first cycle after release.
- With MEM_ARB_PERF_EN: 10 cycles with H, D, I all requesting, lock off → gnt_cnt_h=10, conflict_cnt=10, gnt_cnt_d=gnt_cnt_i=0.
